// File: rtl/issue_queue_pkg.sv
// ============================================================================
// Module      : issue_queue_pkg
// Description : Shared types, widths and helpers for the issue queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_queue_pkg;

  localparam int TAG_W     = 6;
  localparam int PAYLOAD_W = 170;

  // Payload bit fields consumed by EXE
  localparam int PL_JUMP_BIT  = 98;
  localparam int PL_JR_BIT    = 92;
  localparam int PL_ALT_PC_HI = 132;
  localparam int PL_ALT_PC_LO = 101;

  // One queue slot; widths are fixed by the package constants above
  typedef struct packed {
    logic                 valid;
    logic                 rdy_a;
    logic                 rdy_b;
    logic [TAG_W-1:0]     tag_a;
    logic [TAG_W-1:0]     tag_b;
    logic [31:0]          val_a;
    logic [31:0]          val_b;
    logic [TAG_W-1:0]     dest_tag;
    logic [31:0]          instr_num;
    logic [PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  // A not-yet-ready source is woken by a valid broadcast of its tag; tag 0 never wakes
  function automatic logic bcast_hit(input logic             rdy,
                                     input logic [TAG_W-1:0] tag,
                                     input logic             bvalid,
                                     input logic [TAG_W-1:0] btag);
    return !rdy && bvalid && (btag != '0) && (btag == tag);
  endfunction

  function automatic logic pl_is_jump(input logic [PAYLOAD_W-1:0] pl);
    return pl[PL_JUMP_BIT];
  endfunction

  function automatic logic pl_is_jr(input logic [PAYLOAD_W-1:0] pl);
    return pl[PL_JR_BIT];
  endfunction

  function automatic logic [31:0] pl_alt_pc(input logic [PAYLOAD_W-1:0] pl);
    return pl[PL_ALT_PC_HI:PL_ALT_PC_LO];
  endfunction

endpackage

`default_nettype wire

// File: rtl/issue_queue_wakeup.sv
// ============================================================================
// Module      : iq_entry_wakeup
// Description : Tag compare and ready/value capture for one source operand of
//               one queue slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_entry_wakeup
  import issue_queue_pkg::*;
(
  input  logic             valid_i,
  input  logic             rdy_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [31:0]      val_i,
  input  logic             bcast_valid_i,
  input  logic [TAG_W-1:0] bcast_tag_i,
  input  logic [31:0]      bcast_val_i,
  output logic             rdy_o,
  output logic [31:0]      val_o
);

  logic w_hit;

  assign w_hit = valid_i && bcast_hit(rdy_i, tag_i, bcast_valid_i, bcast_tag_i);
  assign rdy_o = rdy_i | w_hit;
  assign val_o = w_hit ? bcast_val_i : val_i;

endmodule

`default_nettype wire

// File: rtl/issue_queue.sv
// ============================================================================
// Module      : issue_queue
// Description : Compacting, oldest-first issue queue feeding EXE. Holds
//               renamed instructions until both operands are ready, wakes
//               them from the result broadcast and issues one per cycle on
//               registered outputs. Slot 0 is always the oldest entry.
//               TAG_W/PAYLOAD_W must match the package constants because the
//               slot struct is sized from them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = issue_queue_pkg::TAG_W,
  parameter int PAYLOAD_W = issue_queue_pkg::PAYLOAD_W
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [TAG_W-1:0]             disp_srcA_tag,
  input  logic                         disp_srcA_rdy,
  input  logic [31:0]                  disp_srcA_val,
  input  logic [TAG_W-1:0]             disp_srcB_tag,
  input  logic                         disp_srcB_rdy,
  input  logic [31:0]                  disp_srcB_val,
  input  logic [TAG_W-1:0]             disp_dest_tag,
  input  logic [31:0]                  disp_instr_num,
  input  logic [PAYLOAD_W-1:0]         disp_payload,
  input  logic                         bcast_valid,
  input  logic [TAG_W-1:0]             bcast_tag,
  input  logic [31:0]                  bcast_val,
  input  logic                         exe_stall,
  output logic                         iss_valid,
  output logic [31:0]                  iss_opA,
  output logic [31:0]                  iss_opB,
  output logic [TAG_W-1:0]             iss_dest_tag,
  output logic [31:0]                  iss_instr_num,
  output logic [PAYLOAD_W-1:0]         iss_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  import issue_queue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  iq_entry_t              ent_q [DEPTH];
  iq_entry_t              ent_d [DEPTH];
  iq_entry_t              woken [DEPTH+1];   // extra top slot is an empty filler for compaction
  iq_entry_t              new_ent;
  logic [CNT_W-1:0]       count_q, count_d, wr_idx;

  logic                   iss_valid_q, iss_valid_d;
  logic [31:0]            iss_opa_q, iss_opa_d;
  logic [31:0]            iss_opb_q, iss_opb_d;
  logic [TAG_W-1:0]       iss_dest_q, iss_dest_d;
  logic [31:0]            iss_inum_q, iss_inum_d;
  logic [PAYLOAD_W-1:0]   iss_pl_q, iss_pl_d;

  logic [DEPTH-1:0]       wk_rdy_a, wk_rdy_b;
  logic [31:0]            wk_val_a [DEPTH];
  logic [31:0]            wk_val_b [DEPTH];
  logic [DEPTH-1:0]       sel_oh, shift_vec;
  logic                   sel_found, do_issue, accept;

  assign disp_ready    = (count_q < CNT_W'(DEPTH));
  assign count         = count_q;
  assign iss_valid     = iss_valid_q;
  assign iss_opA       = iss_opa_q;
  assign iss_opB       = iss_opb_q;
  assign iss_dest_tag  = iss_dest_q;
  assign iss_instr_num = iss_inum_q;
  assign iss_payload   = iss_pl_q;

  // Per-slot wakeup for both sources
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
    iq_entry_wakeup u_wake_a (
      .valid_i       (ent_q[gi].valid),
      .rdy_i         (ent_q[gi].rdy_a),
      .tag_i         (ent_q[gi].tag_a),
      .val_i         (ent_q[gi].val_a),
      .bcast_valid_i (bcast_valid),
      .bcast_tag_i   (bcast_tag),
      .bcast_val_i   (bcast_val),
      .rdy_o         (wk_rdy_a[gi]),
      .val_o         (wk_val_a[gi])
    );
    iq_entry_wakeup u_wake_b (
      .valid_i       (ent_q[gi].valid),
      .rdy_i         (ent_q[gi].rdy_b),
      .tag_i         (ent_q[gi].tag_b),
      .val_i         (ent_q[gi].val_b),
      .bcast_valid_i (bcast_valid),
      .bcast_tag_i   (bcast_tag),
      .bcast_val_i   (bcast_val),
      .rdy_o         (wk_rdy_b[gi]),
      .val_o         (wk_val_b[gi])
    );
  end

  // Merge wakeup results back into full slot images
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i]       = ent_q[i];
      woken[i].rdy_a = wk_rdy_a[i];
      woken[i].rdy_b = wk_rdy_b[i];
      woken[i].val_a = wk_val_a[i];
      woken[i].val_b = wk_val_b[i];
    end
    woken[DEPTH] = '0;
  end

  // Oldest-ready select on registered state; shift_vec marks the selected slot and everything above it
  always_comb begin
    sel_oh    = '0;
    shift_vec = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && ent_q[i].valid && ent_q[i].rdy_a && ent_q[i].rdy_b) begin
        sel_oh[i] = 1'b1;
        sel_found = 1'b1;
      end
      shift_vec[i] = sel_found;
    end
  end

  // Queue next state: compaction, dispatch write with broadcast bypass, flush
  always_comb begin
    do_issue = sel_found && !exe_stall;
    accept   = disp_valid && disp_ready && !flush;
    wr_idx   = count_q - CNT_W'(do_issue);

    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.tag_a     = disp_srcA_tag;
    new_ent.tag_b     = disp_srcB_tag;
    new_ent.rdy_a     = disp_srcA_rdy;
    new_ent.rdy_b     = disp_srcB_rdy;
    new_ent.val_a     = disp_srcA_val;
    new_ent.val_b     = disp_srcB_val;
    new_ent.dest_tag  = disp_dest_tag;
    new_ent.instr_num = disp_instr_num;
    new_ent.payload   = disp_payload;
    if (bcast_hit(disp_srcA_rdy, disp_srcA_tag, bcast_valid, bcast_tag)) begin
      new_ent.rdy_a = 1'b1;
      new_ent.val_a = bcast_val;
    end
    if (bcast_hit(disp_srcB_rdy, disp_srcB_tag, bcast_valid, bcast_tag)) begin
      new_ent.rdy_b = 1'b1;
      new_ent.val_b = bcast_val;
    end

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (do_issue && shift_vec[i]) ? woken[i+1] : woken[i];
      if (accept && (wr_idx == CNT_W'(i))) begin
        ent_d[i] = new_ent;
      end
      if (flush) begin
        ent_d[i].valid = 1'b0;
      end
    end

    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q - CNT_W'(do_issue) + CNT_W'(accept);
    end
  end

  // Issue register next state: load selected slot, go idle, or hold under stall
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_opa_d   = iss_opa_q;
    iss_opb_d   = iss_opb_q;
    iss_dest_d  = iss_dest_q;
    iss_inum_d  = iss_inum_q;
    iss_pl_d    = iss_pl_q;
    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (!exe_stall) begin
      iss_valid_d = sel_found;
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_oh[i]) begin
          iss_opa_d  = ent_q[i].val_a;
          iss_opb_d  = ent_q[i].val_b;
          iss_dest_d = ent_q[i].dest_tag;
          iss_inum_d = ent_q[i].instr_num;
          iss_pl_d   = ent_q[i].payload;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_opa_q   <= '0;
      iss_opb_q   <= '0;
      iss_dest_q  <= '0;
      iss_inum_q  <= '0;
      iss_pl_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_opa_q   <= iss_opa_d;
      iss_opb_q   <= iss_opb_d;
      iss_dest_q  <= iss_dest_d;
      iss_inum_q  <= iss_inum_d;
      iss_pl_q    <= iss_pl_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Single-issue, in-order-age issue queue that sits directly upstream of the EXE stage.
- Accepts renamed instructions from dispatch and holds them until both source operands are ready. Readiness comes from the dispatch flags or from the EXE/MEM result broadcast.
- Each cycle it selects the oldest ready entry and presents its operands and info bundle to EXE on registered outputs.
- It is flushed by EXE's branch/jump redirect.

Parameters:
DEPTH, 8, number of queue entries (power of 2 not required, ≥2)
TAG_W, 6, physical register tag width
PAYLOAD_W, 170, width of the per-instruction info bundle passed through to EXE

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
flush  in  1  EXE redirect; kill all queue contents
disp_valid  in  1  dispatch presents an instruction
disp_ready  out  1  queue can accept (count < DEPTH)
disp_srcA_tag  in  TAG_W  physical tag of operand A
disp_srcA_rdy  in  1  operand A value already known
disp_srcA_val  in  32  operand A value (valid when rdy)
disp_srcB_tag  in  TAG_W  physical tag of operand B
disp_srcB_rdy  in  1  operand B already known
disp_srcB_val  in  32  operand B value
disp_dest_tag  in  TAG_W  destination physical tag
disp_instr_num  in  32  ROB sequence number
disp_payload  in  PAYLOAD_W  info bundle (control, PC, alt PC, flags)
bcast_valid  in  1  result broadcast valid
bcast_tag  in  TAG_W  broadcast destination tag
bcast_val  in  32  broadcast value
exe_stall  in  1  EXE cannot accept a new instruction
iss_valid  out  1  issued instruction valid
iss_opA  out  32  operand A
iss_opB  out  32  operand B
iss_dest_tag  out  TAG_W  destination tag
iss_instr_num  out  32  sequence number
iss_payload  out  PAYLOAD_W  info bundle
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, RESET=1): all entry valid bits 0, count=0, iss_valid=0, iss_opA/opB/dest_tag/instr_num/payload=0. disp_ready=1 after reset releases.
- Storage is a compacting queue. Entry 0 is the oldest. Valid entries are always contiguous from index 0.
- Dispatch:
  - Accepted when disp_valid && disp_ready && !flush.
  - Written at index (count − issued_this_cycle), i.e. after compaction.
  - disp_ready = (count < DEPTH), from registered count. It does not credit a same-cycle issue.
- Wakeup: every cycle, for each valid entry and each source with rdy=0, if bcast_valid && bcast_tag==src_tag, set rdy=1 and capture bcast_val.
  - Broadcast with tag 0 is ignored.
- Dispatch bypass: if a dispatched source has rdy=0 and matches the same-cycle broadcast, it enters with rdy=1 and bcast_val.
- Select: the lowest-index valid entry with both rdy bits set, evaluated on registered state.
  - An entry woken in cycle N is selectable in cycle N+1.
- Issue:
  - If an entry is selected and !exe_stall, then on the next edge iss_* is loaded from it, iss_valid=1, and the entry is removed. Entries above it shift down one.
  - If no entry is ready and !exe_stall: iss_valid=0; other iss_* hold.
  - If exe_stall: iss_* hold unchanged and no entry is removed. Wakeup and dispatch still occur.
- Latency: dispatch with both operands ready at edge N → earliest iss_valid at edge N+1 (visible N+1 to N+2).
- Simultaneous dispatch + issue when full: dispatch is rejected (disp_ready=0). count becomes DEPTH−1.
- Flush:
  - Highest priority over dispatch, issue and wakeup.
  - At the edge: all entries invalid, count=0, iss_valid=0. A dispatch presented in the flush cycle is dropped.
- Wakeup of a selected entry's other source is irrelevant: selection needs both already set.

Decomposition:
- Shared package holds:
  - localparams TAG_W=6 and PAYLOAD_W=170
  - the payload bit-field constants (jump bit 98, jr bit 92, alt PC 132:101) used by EXE
  - an entry struct: valid, rdyA/B, tagA/B, valA/B, dest_tag, instr_num, payload
- One natural sub-module, iq_entry_wakeup: a per-entry tag compare plus rdy/value capture, instantiated 2×DEPTH.
- The priority-select encoder stays inline.

Test Plan:
- Reset mid-operation: fill 3 entries, assert RESET for 1 cycle → count=0, iss_valid=0, iss_opA=0, disp_ready=1 immediately.
- Ready dispatch: dispatch A=5,B=7 both rdy, dest 12 → next edge iss_valid=1, iss_opA=5, iss_opB=7, iss_dest_tag=12, count returns to 0.
- Wakeup order: dispatch X (srcA tag 9 not ready) then Y (both ready) → Y issues first. Broadcast tag 9 val 0xDEAD → X issues 2 cycles later with iss_opA=0xDEAD.
- Bypass and tag 0:
  - Dispatch srcB tag 4 not ready with same-cycle bcast tag 4 val 0x11 → issues next edge with opB=0x11.
  - bcast tag 0 wakes nothing.
- Full/stall: hold exe_stall=1, dispatch DEPTH=8 ready instrs → disp_ready=0 at count 8, iss_* unchanged. Release stall → one issue per cycle in dispatch order (instr_num 0..7).
- Flush: 5 entries queued plus disp_valid in the same cycle as flush=1 → count=0, iss_valid=0 next edge, and the dispatched instruction is never issued.
